// File: rtl/regfile_initiator.sv
// Command-driven initiator for the mem_regfile BRAM-style port, one transaction in flight.
// Optional poll-read support is compiled in with REGFILE_INITIATOR_POLL_EN.
module regfile_initiator #(
    parameter int Naddr      = 4,
    parameter int RD_LATENCY = 1,
    parameter int POLL_MAX   = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic             cmd_poll,
    input  logic [Naddr-1:0] cmd_addr,
    input  logic [31:0]      cmd_wdata,
    input  logic [3:0]       cmd_wstrb,
    input  logic [31:0]      cmd_mask,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic             en,
    output logic [3:0]       we,
    output logic [Naddr-1:0] addr,
    output logic [31:0]      wr_data,
    input  logic [31:0]      rd_data
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t     state;
    logic [2:0] cnt;
    logic       lat_write;
    logic       accept;
    logic       last_wait;
    logic       again;

    assign accept    = (state == IDLE) && cmd_valid && cmd_ready;
    assign last_wait = (state == WAIT) && (cnt <= 3'd1);

`ifdef REGFILE_INITIATOR_POLL_EN
    logic        lat_poll;
    logic [31:0] lat_match;
    logic [31:0] lat_mask;
    logic [15:0] reads;
    logic [15:0] reads_nxt;
    logic        hit;

    assign hit       = ((rd_data ^ lat_match) & lat_mask) == 32'h0;
    assign reads_nxt = (reads == 16'hffff) ? reads : reads + 16'd1;
    assign again     = lat_poll && !hit && (reads_nxt < 16'(POLL_MAX));

    // Reads counter saturates; it only ever grows within one poll command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_poll  <= 1'b0;
            lat_match <= 32'h0;
            lat_mask  <= 32'h0;
            reads     <= 16'h0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                lat_poll  <= cmd_poll && !cmd_write;
                lat_match <= cmd_wdata;
                lat_mask  <= cmd_mask;
                reads     <= 16'h0;
                rsp_err   <= 1'b0;
            end
            if (last_wait) begin
                reads <= reads_nxt;
                if (!again)
                    rsp_err <= lat_poll && !hit;
            end
        end
    end
`else
    logic unused_poll;

    assign again       = 1'b0;
    assign rsp_err     = 1'b0;
    assign unused_poll = ^{cmd_poll, cmd_mask, 32'(POLL_MAX)};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            en        <= 1'b0;
            we        <= 4'h0;
            addr      <= '0;
            wr_data   <= 32'h0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            cnt       <= 3'd0;
            lat_write <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        en        <= 1'b1;
                        addr      <= cmd_addr;
                        lat_write <= cmd_write;
                        if (cmd_write) begin
                            we      <= cmd_wstrb;
                            wr_data <= cmd_wdata;
                        end else begin
                            we <= 4'h0;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    en <= 1'b0;
                    we <= 4'h0;
                    if (lat_write) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= 32'h0;
                        state     <= RESP;
                    end else begin
                        cnt   <= 3'(RD_LATENCY);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt > 3'd1) begin
                        cnt <= cnt - 3'd1;
                    end else if (again) begin
                        en    <= 1'b1;
                        state <= ISSUE;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rd_data;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_initiator.sv
// Bench for regfile_initiator: behavioural register file, vector table,
// response scoreboard and hand-written backpressure/reset/poll sequences.
module tb_regfile_initiator;

    localparam int NA  = 4;
    localparam int LAT = 1;
    localparam int PMX = 255;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write, cmd_poll;
    logic [NA-1:0] cmd_addr;
    logic [31:0]   cmd_wdata, cmd_mask;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [31:0]   rsp_rdata;
    logic          en;
    logic [3:0]    we;
    logic [NA-1:0] addr;
    logic [31:0]   wr_data, rd_data;

    regfile_initiator #(
        .Naddr(NA), .RD_LATENCY(LAT), .POLL_MAX(PMX)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_poll(cmd_poll),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_wstrb(cmd_wstrb), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .en(en), .we(we), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural responder, RD_LATENCY = 1, read-before-write
    logic [31:0] mem [16];
    logic        mem_init, clr7, flip_arm;
    int          flip_cnt = 0;
    logic [31:0] pipe [LAT];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int n = 0; n < 16; n++)
                mem[n] <= {8{4'(n)}};
        end else begin
            if (clr7)
                mem[7][0] <= 1'b0;
            if (en) begin
                for (int b = 0; b < 4; b++)
                    if (we[b])
                        mem[addr][8*b +: 8] <= wr_data[8*b +: 8];
                if (flip_arm && addr == 4'd7) begin
                    flip_cnt <= flip_cnt + 1;
                    if (flip_cnt == 3)
                        mem[7][0] <= 1'b1;
                end
            end
            if (!flip_arm)
                flip_cnt <= 0;
        end
        pipe[0] <= mem[addr];
        for (int k = 1; k < LAT; k++)
            pipe[k] <= pipe[k-1];
    end
    assign rd_data = pipe[LAT-1];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic          w;
        logic [NA-1:0] a;
        logic [31:0]   d;
        logic [3:0]    s;
        logic [31:0]   exp;
    } vec_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    int          en_cnt = 0, en_cyc = 0, rsp_cyc = 0, rsp_rises = 0;
    logic [3:0]  en_we;
    logic [NA-1:0] en_addr;
    logic        rsp_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (en) begin
                en_cnt++;
                en_cyc  = cyc;
                en_we   = we;
                en_addr = addr;
            end
            if (rsp_valid && !rsp_prev) begin
                rsp_cyc = cyc;
                rsp_rises++;
            end
            rsp_prev = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_rsp: got rdata %h with no response pending", rsp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
        end
    endtask

    task automatic send(input logic w, input logic [NA-1:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic p, input logic [31:0] m,
                        input logic [31:0] exp_rd, input logic exp_er, output int acc);
        bit ok = 0;
        acc = -1;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a;
        cmd_wdata = d; cmd_wstrb = s; cmd_poll = p; cmd_mask = m;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                exp_q.push_back('{rdata: exp_rd, err: exp_er});
                @(posedge clk);
                #1;
                acc = cyc;
            end
        end
        cmd_valid = 1'b0;
        cmd_poll  = 1'b0;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: cmd_ready low for 100 cycles, expected high");
        end
    endtask

    task automatic drain(input int lim);
        int i = 0;
        while (exp_q.size() != 0 && i < lim) begin
            @(negedge clk);
            i++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[10];
    int   acc, a1, a2, e0, c, seen;

    initial begin
        tbl[0] = '{1'b0, 4'd5,  32'h0,         4'h0, 32'h5555_5555};
        tbl[1] = '{1'b1, 4'd3,  32'hA5A5_1234, 4'h3, 32'h0};
        tbl[2] = '{1'b0, 4'd3,  32'h0,         4'h0, 32'h3333_1234};
        tbl[3] = '{1'b1, 4'd0,  32'hFFFF_FFFF, 4'h0, 32'h0};
        tbl[4] = '{1'b0, 4'd0,  32'h0,         4'h0, 32'h0000_0000};
        tbl[5] = '{1'b1, 4'd15, 32'h1234_5678, 4'hF, 32'h0};
        tbl[6] = '{1'b0, 4'd15, 32'h0,         4'h0, 32'h1234_5678};
        tbl[7] = '{1'b1, 4'd9,  32'hDEAD_BEEF, 4'hC, 32'h0};
        tbl[8] = '{1'b0, 4'd9,  32'h0,         4'h0, 32'hDEAD_9999};
        tbl[9] = '{1'b0, 4'd14, 32'h0,         4'h0, 32'hEEEE_EEEE};

        rst = 1'b1; mem_init = 1'b1; clr7 = 1'b0; flip_arm = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_poll = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; cmd_mask = '0;
        rsp_ready = 1'b1;
        fork monitor(); join_none

        repeat (2) @(negedge clk);
        chk("rst_en",        32'(en),        32'h0);
        chk("rst_we",        32'(we),        32'h0);
        chk("rst_addr",      32'(addr),      32'h0);
        chk("rst_wr_data",   wr_data,        32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata,      32'h0);
        chk("rst_rsp_err",   32'(rsp_err),   32'h0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; mem_init = 1'b0;

        for (int i = 0; i < 10; i++) begin
            e0 = en_cnt;
            send(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, 1'b0, 32'h0,
                 tbl[i].w ? 32'h0 : tbl[i].exp, 1'b0, acc);
            drain(20);
            chk($sformatf("v%0d_en_pulses", i), 32'(en_cnt - e0), 32'd1);
            chk($sformatf("v%0d_we", i), 32'(en_we), tbl[i].w ? 32'(tbl[i].s) : 32'h0);
            chk($sformatf("v%0d_addr", i), 32'(en_addr), 32'(tbl[i].a));
            chk($sformatf("v%0d_en_cyc", i), 32'(en_cyc - acc), 32'd0);
            chk($sformatf("v%0d_latency", i), 32'(rsp_cyc - en_cyc),
                tbl[i].w ? 32'd1 : 32'(1 + LAT));
        end

        // back-to-back throughput with rsp_ready high
        send(1'b1, 4'd1, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 1'b0, a1);
        send(1'b1, 4'd1, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 1'b0, a2);
        drain(20);
        chk("wr_throughput", 32'(a2 - a1), 32'd3);
        send(1'b0, 4'd1, 32'h0, 4'h0, 1'b0, 32'h0, 32'h1111_1111, 1'b0, a1);
        send(1'b0, 4'd1, 32'h0, 4'h0, 1'b0, 32'h0, 32'h1111_1111, 1'b0, a2);
        drain(20);
        chk("rd_throughput", 32'(a2 - a1), 32'(3 + LAT));

        // response backpressure
        rsp_ready = 1'b0;
        send(1'b0, 4'd6, 32'h0, 4'h0, 1'b0, 32'h0, 32'h6666_6666, 1'b0, acc);
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        chk("bp_rsp_seen", 32'(seen), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_rdata", rsp_rdata, 32'h6666_6666);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        @(posedge clk); #1;
        c = cyc;
        rsp_ready = 1'b1;
        send(1'b0, 4'd4, 32'h0, 4'h0, 1'b0, 32'h0, 32'h4444_4444, 1'b0, acc);
        chk("bp_resume_cyc", 32'(acc - c), 32'd2);
        drain(20);

        // reset in the cycle after a read is accepted
        send(1'b0, 4'd8, 32'h0, 4'h0, 1'b0, 32'h0, 32'h8888_8888, 1'b0, acc);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("mid_rst_en", 32'(en), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        e0 = rsp_rises;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_cmd_ready_low", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        chk("post_rst_cmd_ready_high", 32'(cmd_ready), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        chk("dropped_rsp", 32'(rsp_rises - e0), 32'd0);
        send(1'b0, 4'd2, 32'h0, 4'h0, 1'b0, 32'h0, 32'h2222_2222, 1'b0, acc);
        drain(20);

`ifdef REGFILE_INITIATOR_POLL_EN
        clr7 = 1'b1;
        @(posedge clk); #1;
        clr7 = 1'b0;
        flip_arm = 1'b1;
        e0 = en_cnt;
        send(1'b0, 4'd7, 32'h1, 4'h0, 1'b1, 32'h1, 32'h7777_7777, 1'b0, acc);
        drain(100);
        chk("poll_hit_reads", 32'(en_cnt - e0), 32'd5);
        flip_arm = 1'b0;
        e0 = en_cnt;
        send(1'b0, 4'd7, 32'h0, 4'h0, 1'b1, 32'h1, 32'h7777_7777, 1'b1, acc);
        drain(4 * PMX + 50);
        chk("poll_timeout_reads", 32'(en_cnt - e0), 32'(PMX));
`else
        e0 = en_cnt;
        send(1'b0, 4'd7, 32'h0, 4'h0, 1'b1, 32'h1, 32'h7777_7777, 1'b0, acc);
        drain(20);
        chk("poll_ignored_reads", 32'(en_cnt - e0), 32'd1);
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_initiator.md
# regfile_initiator

Command-driven initiator for the BRAM-style register-file port (`en`/`we`/`addr`/`wr_data`/`rd_data`) served by `mem_regfile`. It lets fabric logic read and write the register file over a valid/ready command channel instead of the processor-side BRAM controller. It sits between a local sequencer or test harness and a `mem_regfile` instance, one transaction outstanding at a time. Read responses are returned on a valid/ready response channel.

## Interface
- `Naddr`, 4, word-address width; must match the responder's `Naddr`.
- `RD_LATENCY`, 1, cycles from the `en` cycle to the cycle `rd_data` is valid; range 1..4.
- `POLL_MAX`, 255, maximum poll reads before timeout; only used with `REGFILE_INITIATOR_POLL_EN`.
- `clk  in  1`  sole clock; `en`, `we`, `addr`, `wr_data` and `rd_data` are all in this domain.
- `rst  in  1`  asynchronous, active-high reset.
- `cmd_valid  in  1`  command present.
- `cmd_ready  out  1`  command accepted when high together with `cmd_valid` at a rising edge.
- `cmd_write  in  1`  1 = write, 0 = read.
- `cmd_poll  in  1`  poll-read; only with `REGFILE_INITIATOR_POLL_EN`, otherwise ignored.
- `cmd_addr  in  Naddr`  word address.
- `cmd_wdata  in  32`  write data; poll match value.
- `cmd_wstrb  in  4`  byte enables for writes; ignored for reads.
- `cmd_mask  in  32`  poll compare mask; only with `REGFILE_INITIATOR_POLL_EN`.
- `rsp_valid  out  1`  response present.
- `rsp_ready  in  1`  response consumed when high together with `rsp_valid`.
- `rsp_rdata  out  32`  read data; 0 for writes.
- `rsp_err  out  1`  poll timeout; 0 otherwise.
- `en  out  1`  port enable to responder.
- `we  out  4`  byte write enables to responder.
- `addr  out  Naddr`  word address to responder.
- `wr_data  out  32`  write data to responder.
- `rd_data  in  32`  read data from responder.

## Operation
- States:
  - IDLE.
  - ISSUE: `en` cycle.
  - WAIT: counts `RD_LATENCY`.
  - RESP: holds the response.
- IDLE:
  - `cmd_ready` = 1.
  - On handshake, latch the command and go to ISSUE.
- ISSUE, exactly one cycle:
  - `en` = 1, `addr` = latched address.
  - Write: `we` = latched strobe, `wr_data` = latched data, then go to RESP.
  - Read: `we` = 0, then go to WAIT.
  - A write with `cmd_wstrb`=0 still pulses `en` with `we`=0 and still returns a response.
- WAIT:
  - Count from `RD_LATENCY` down to 1.
  - At the end of the last count cycle, capture `rd_data` into `rsp_rdata` and go to RESP.
- RESP:
  - `rsp_valid` = 1; outputs stay stable until `rsp_ready`.
  - On handshake, return to IDLE.
- Outside ISSUE: `en`=0 and `we`=0. `addr` and `wr_data` hold their last values.
- `cmd_ready` is 0 in every state except IDLE. The block is strictly one-outstanding.
- All outputs are registered.
- Reset (asynchronous, any state, including mid-transaction):
  - State returns to IDLE.
  - `en`, `we`, `addr`, `wr_data`, `rsp_valid`, `rsp_rdata` and `rsp_err` all = 0.
  - `cmd_ready` = 0 while `rst` is high and 1 from the first edge after release.
  - Any in-flight transaction is dropped and no response is produced.

## Timing
- Command accepted at edge T:
  - `en` is high during cycle T+1.
  - Write: `rsp_valid` rises in cycle T+2.
  - Read: `rd_data` is sampled at the end of cycle T+1+`RD_LATENCY`, and `rsp_valid` rises in cycle T+2+`RD_LATENCY`.
- With `rsp_ready` tied high, back-to-back throughput is:
  - Writes: one per 3 cycles.
  - Reads: one per 3+`RD_LATENCY` cycles.
- If `rsp_ready` and a new `cmd_valid` arrive in the same cycle, the command is not accepted until the following IDLE cycle.

## Configuration
- `REGFILE_INITIATOR_POLL_EN` defined:
  - A read with `cmd_poll`=1 repeats ISSUE/WAIT until `(rd_data & cmd_mask) == (cmd_wdata & cmd_mask)` or `POLL_MAX` reads have completed.
  - On a match: response with `rsp_err`=0, `rsp_rdata` = matching word.
  - On timeout: `rsp_err`=1, `rsp_rdata` = last word read.
  - The next ISSUE starts the cycle after each mismatching capture.
  - The read counter is 8+ bits and saturates; there is no wrap.
- `REGFILE_INITIATOR_POLL_EN` undefined:
  - `cmd_poll` and `cmd_mask` are ignored; a poll command is a plain read.
  - `rsp_err` is constant 0, and the poll logic is absent.

## Test plan
- Bench setup for all scenarios: behavioural responder with `RD_LATENCY`=1, word n initialised to 0xnnnn_nnnn, `rsp_ready`=1.
- Read addr 5 -> `en` 1 cycle, `we`=0, `addr`=5; `rsp_rdata`=0x5555_5555 three cycles after accept; `rsp_err`=0.
- Write addr 3, data 0xA5A5_1234, `cmd_wstrb`=4'b0011, then read addr 3 -> `we`=4'b0011 during the `en` cycle; read returns 0x3333_1234.
- Hold `rsp_ready`=0 for 5 cycles after a read -> `rsp_valid` and `rsp_rdata` stable; `cmd_ready`=0 throughout; accept resumes one cycle after the response handshake.
- Assert `rst` in the cycle after a read is accepted -> `en`=0 immediately, no `rsp_valid` ever for that read; next read of addr 2 returns 0x2222_2222.
- POLL_EN: poll addr 7, mask 0x1, match 0x1; responder flips bit 0 after 4 reads -> response on the 5th read, `rsp_err`=0. With `POLL_MAX`=3 and no flip -> `rsp_err`=1 after exactly 3 `en` pulses.
